// File: rtl/cpu_pkg.sv
// Shared core definitions: PC increment, direction-counter init values, PC field positions.
// No latency: constants and constant functions only.
// No flow control involved.
package cpu_pkg;

  // Sequential fetch advances by one 32-bit instruction.
  localparam int unsigned PC_INC = 4;

  // Instructions are word aligned, so the two lowest PC bits never index anything.
  localparam int unsigned PC_IDX_LSB = 2;

  // Weakly-taken value: MSB set, all other bits clear.
  function automatic int unsigned ctr_weak_taken(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  // Weakly-not-taken value: just below the taken threshold.
  function automatic int unsigned ctr_weak_not_taken(input int unsigned ctr_w);
    return ctr_weak_taken(ctr_w) - 32'd1;
  endfunction

  // Top bit of the table index inside a PC.
  function automatic int unsigned pc_idx_msb(input int unsigned idx_w);
    return idx_w + PC_IDX_LSB - 1;
  endfunction

  // Lowest bit of the tag inside a PC; the tag runs from here to the PC MSB.
  function automatic int unsigned pc_tag_lsb(input int unsigned idx_w);
    return idx_w + PC_IDX_LSB;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-value logic for branch direction training.
// Combinational, zero latency.
// No flow control; inc and dec together leave the value unchanged.
module sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CTR_W-1:0] ctr_o
);

  // Step toward the requested direction unless already pinned at that end.
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i && !dec_i && (ctr_i != {CTR_W{1'b1}})) begin
      ctr_o = ctr_i + 1'b1;
    end else if (dec_i && !inc_i && (ctr_i != {CTR_W{1'b0}})) begin
      ctr_o = ctr_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and branch statistics.
// Lookup is combinational (0 cycles); training and statistics take effect at the next clk edge.
// No backpressure: one lookup and one update are accepted every cycle.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CTR_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              flush_all,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispredict_cnt
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = ADDR_W - 2 - IDX_W;
  localparam int unsigned IDX_MSB = pc_idx_msb(IDX_W);
  localparam int unsigned TAG_LSB = pc_tag_lsb(IDX_W);

  localparam logic [CTR_W-1:0]  CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0]  CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));
  localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);

  // Table storage: valid bits packed so flush is a single clear.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_d   [ENTRIES];
  logic [ADDR_W-3:0]  tgt_q   [ENTRIES];
  logic [ADDR_W-3:0]  tgt_d   [ENTRIES];
  logic [CTR_W-1:0]   ctr_q   [ENTRIES];
  logic [CTR_W-1:0]   ctr_d   [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // Alignment bits carry no information for a word-aligned ISA.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Lookup side.
  logic [IDX_W-1:0] lidx;
  logic [TAG_W-1:0] ltag;
  assign lidx = lookup_pc[IDX_MSB:PC_IDX_LSB];
  assign ltag = lookup_pc[ADDR_W-1:TAG_LSB];

  // Predict from current table contents only; a same-cycle update is not forwarded.
  always_comb begin
    pred_hit    = valid_q[lidx] && (tag_q[lidx] == ltag);
    pred_taken  = pred_hit && ctr_q[lidx][CTR_W-1];
    pred_target = pred_taken ? {tgt_q[lidx], 2'b00} : (lookup_pc + INC);
  end

  // Update side.
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             upd_hit;
  logic [CTR_W-1:0] ctr_nxt;
  assign uidx    = upd_pc[IDX_MSB:PC_IDX_LSB];
  assign utag    = upd_pc[ADDR_W-1:TAG_LSB];
  assign upd_hit = valid_q[uidx] && (tag_q[uidx] == utag);

  sat_counter #(
    .CTR_W (CTR_W)
  ) u_sat_counter (
    .ctr_i (ctr_q[uidx]),
    .inc_i (upd_taken),
    .dec_i (!upd_taken),
    .ctr_o (ctr_nxt)
  );

  // Train the indexed entry; a flush in the same cycle takes priority and drops the update.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (flush_all) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_d[uidx] = ctr_nxt;
        if (upd_taken) begin
          tgt_d[uidx] = upd_target[ADDR_W-1:2];
        end
      end else if (upd_taken) begin
        valid_d[uidx] = 1'b1;
        tag_d[uidx]   = utag;
        tgt_d[uidx]   = upd_target[ADDR_W-1:2];
        ctr_d[uidx]   = CTR_WT;
      end
    end
  end

  // Statistics count every report, flush or not, and wrap naturally.
  assign branch_cnt_d     = branch_cnt_q + {31'd0, upd_valid};
  assign mispredict_cnt_d = mispredict_cnt_q + {31'd0, upd_valid & upd_mispredict};

  // Table registers; counters start weakly not-taken so a fresh allocation is the only way to predict taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

  // Statistics registers, updated on the same edge as the table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
